// File: rtl/writeback_queue.sv
// Writeback buffer in front of register_file: in-order circular queue that accepts
// up to SUPER_SCALAR_WIDTH results per cycle and drains the oldest onto the write ports.

package writeback_queue_pkg;
    localparam int WBQ_REG_ADDR_WIDTH = 5;
    localparam int WBQ_DATA_WIDTH     = 32;

    typedef logic [WBQ_DATA_WIDTH-1:0] word_t;

    typedef struct packed {
        logic                          write_enable;
        logic [WBQ_REG_ADDR_WIDTH-1:0] register;
        word_t                         data;
    } RegisterFileWriteRequest;
endpackage

module writeback_queue #(
    parameter int SUPER_SCALAR_WIDTH = 2,
    parameter int DEPTH              = 8,
    parameter int REG_ADDR_WIDTH     = writeback_queue_pkg::WBQ_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH         = writeback_queue_pkg::WBQ_DATA_WIDTH
) (
    input  logic                                                  clk_in,
    input  logic                                                  rst_in,
    input  logic [SUPER_SCALAR_WIDTH-1:0]                         result_valid_in,
    input  logic [SUPER_SCALAR_WIDTH-1:0][REG_ADDR_WIDTH-1:0]     result_register_in,
    input  logic [SUPER_SCALAR_WIDTH-1:0][DATA_WIDTH-1:0]         result_data_in,
    output logic                                                  result_ready_out,
    input  logic                                                  drain_enable_in,
    output writeback_queue_pkg::RegisterFileWriteRequest [SUPER_SCALAR_WIDTH-1:0] write_ports_reg_request_out,
    output logic [(2**REG_ADDR_WIDTH)-1:0]                        pending_register_mask_out,
    output logic [$clog2(DEPTH+1)-1:0]                            count_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [REG_ADDR_WIDTH-1:0] reg_mem_q  [DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem_q [DEPTH];

    logic                                  ready;
    logic [CW-1:0]                         accept_cnt;
    logic [CW-1:0]                         drain_n;
    logic [CW-1:0]                         drain_cnt;
    logic [SUPER_SCALAR_WIDTH-1:0]         lane_enq;
    logic [SUPER_SCALAR_WIDTH-1:0][PW-1:0] lane_slot;
    logic [SUPER_SCALAR_WIDTH-1:0][PW-1:0] port_slot;
    logic [PW-1:0]                         occ_off [DEPTH];

    // Conservative: ignores this cycle's drain so ready never depends on drain_enable_in.
    assign ready = !rst_in && ((DEPTH - int'(count_q)) >= SUPER_SCALAR_WIDTH);
    assign result_ready_out = ready;

    // Compact accepted lanes into consecutive slots; register-0 lanes are accepted but dropped.
    always_comb begin
        accept_cnt = '0;
        lane_enq   = '0;
        lane_slot  = '0;
        for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
            lane_enq[i]  = ready && result_valid_in[i] && (result_register_in[i] != '0);
            lane_slot[i] = tail_q + PW'(accept_cnt);
            if (lane_enq[i]) begin
                accept_cnt = accept_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        drain_n   = (count_q < CW'(SUPER_SCALAR_WIDTH)) ? count_q : CW'(SUPER_SCALAR_WIDTH);
        drain_cnt = drain_enable_in ? drain_n : '0;
    end

    always_comb begin
        write_ports_reg_request_out = '0;
        port_slot                   = '0;
        for (int j = 0; j < SUPER_SCALAR_WIDTH; j++) begin
            port_slot[j] = head_q + PW'(j);
            if (CW'(j) < drain_n) begin
                write_ports_reg_request_out[j].write_enable = drain_enable_in && !rst_in;
                write_ports_reg_request_out[j].register     = reg_mem_q[port_slot[j]];
                write_ports_reg_request_out[j].data         = data_mem_q[port_slot[j]];
            end
        end
        // Older writes to a register also written later in the same group are masked.
        for (int j = 0; j < SUPER_SCALAR_WIDTH; j++) begin
            for (int k = j + 1; k < SUPER_SCALAR_WIDTH; k++) begin
                if ((CW'(k) < drain_n) &&
                    (write_ports_reg_request_out[j].register == write_ports_reg_request_out[k].register)) begin
                    write_ports_reg_request_out[j].write_enable = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pending_register_mask_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_off[i] = PW'(i) - head_q;
            if (CW'(occ_off[i]) < count_q) begin
                pending_register_mask_out[reg_mem_q[i]] = 1'b1;
            end
        end
        pending_register_mask_out[0] = 1'b0;
        if (rst_in) begin
            pending_register_mask_out = '0;
        end
    end

    always_comb begin
        head_d  = head_q + PW'(drain_cnt);
        tail_d  = tail_q + PW'(accept_cnt);
        count_d = count_q + accept_cnt - drain_cnt;
    end

    assign count_out = rst_in ? '0 : count_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by head/count.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
            if (lane_enq[i]) begin
                reg_mem_q[lane_slot[i]]  <= result_register_in[i];
                data_mem_q[lane_slot[i]] <= result_data_in[i];
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: reset, single lane, compaction, fill/backpressure,
// collision and concurrent enqueue/drain, with hand-computed expectations.

module tb_writeback_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       valid;
    logic [1:0][4:0]  regs;
    logic [1:0][31:0] data;
    logic             drain_en;
    logic             ready;
    writeback_queue_pkg::RegisterFileWriteRequest [1:0] ports;
    logic [31:0]      mask;
    logic [3:0]       count;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_queue dut (
        .clk_in                      (clk),
        .rst_in                      (rst),
        .result_valid_in             (valid),
        .result_register_in          (regs),
        .result_data_in              (data),
        .result_ready_out            (ready),
        .drain_enable_in             (drain_en),
        .write_ports_reg_request_out (ports),
        .pending_register_mask_out   (mask),
        .count_out                   (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = '0; regs = '0; data = '0; drain_en = 1'b0;
        step();
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b expected 0", ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %0b expected 1", ready); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL idle_count: got %0d expected 0", count); end
        n_cmp++; if (ports[0].write_enable !== 1'b0 || ports[1].write_enable !== 1'b0) begin
            n_bad++; $display("FAIL idle_we: got %0b%0b expected 00", ports[1].write_enable, ports[0].write_enable); end
        n_cmp++; if (mask !== 32'h0) begin n_bad++; $display("FAIL idle_mask: got %0h expected 0", mask); end
        valid = 2'b11; regs[0] = 5'd1; regs[1] = 5'd2; data[0] = 32'h1; data[1] = 32'h2;
        step();
        valid = 2'b01; regs[0] = 5'd3; data[0] = 32'h3;
        step();
        valid = '0;
        #1;
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL pre_rst_count: got %0d expected 3", count); end
        n_cmp++; if (mask !== 32'hE) begin n_bad++; $display("FAIL pre_rst_mask: got %0h expected e", mask); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %0b expected 0", ready); end
        n_cmp++; if (mask !== 32'h0) begin n_bad++; $display("FAIL mid_rst_mask: got %0h expected 0", mask); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
        step();
        rst = 1'b0; drain_en = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL post_rst_count: got %0d expected 0", count); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (ports[0].write_enable !== 1'b0 || ports[1].write_enable !== 1'b0) begin
                n_bad++; $display("FAIL post_rst_no_write: got %0b%0b expected 00", ports[1].write_enable, ports[0].write_enable); end
            step();
        end
    endtask

    task automatic test_single();
        drain_en = 1'b1; valid = 2'b01; regs[0] = 5'd5; data[0] = 32'hDEADBEEF;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %0b expected 1", ready); end
        step();
        valid = '0;
        #1;
        n_cmp++; if (ports[0].write_enable !== 1'b1) begin n_bad++; $display("FAIL single_we: got %0b expected 1", ports[0].write_enable); end
        n_cmp++; if (ports[0].register !== 5'd5) begin n_bad++; $display("FAIL single_reg: got %0d expected 5", ports[0].register); end
        n_cmp++; if (ports[0].data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_data: got %0h expected deadbeef", ports[0].data); end
        n_cmp++; if (ports[1].write_enable !== 1'b0) begin n_bad++; $display("FAIL single_p1_we: got %0b expected 0", ports[1].write_enable); end
        n_cmp++; if (mask !== 32'h20) begin n_bad++; $display("FAIL single_mask: got %0h expected 20", mask); end
        step();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL single_count_after: got %0d expected 0", count); end
        n_cmp++; if (mask !== 32'h0) begin n_bad++; $display("FAIL single_mask_after: got %0h expected 0", mask); end
    endtask

    task automatic test_compaction();
        drain_en = 1'b0; valid = 2'b10; regs[1] = 5'd7; data[1] = 32'h11;
        step();
        valid = '0; drain_en = 1'b1;
        #1;
        n_cmp++; if (ports[0].write_enable !== 1'b1 || ports[0].register !== 5'd7 || ports[0].data !== 32'h11) begin
            n_bad++; $display("FAIL compact_port0: got we=%0b r=%0d d=%0h expected we=1 r=7 d=11",
                              ports[0].write_enable, ports[0].register, ports[0].data); end
        n_cmp++; if (ports[1].write_enable !== 1'b0) begin n_bad++; $display("FAIL compact_port1_we: got %0b expected 0", ports[1].write_enable); end
        step();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL compact_drained: got %0d expected 0", count); end
        drain_en = 1'b0; valid = 2'b10; regs[1] = 5'd0; data[1] = 32'h22;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL r0_ready: got %0b expected 1", ready); end
        step();
        valid = '0; drain_en = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL r0_count: got %0d expected 0", count); end
        n_cmp++; if (ports[0].write_enable !== 1'b0) begin n_bad++; $display("FAIL r0_no_write: got %0b expected 0", ports[0].write_enable); end
        n_cmp++; if (mask !== 32'h0) begin n_bad++; $display("FAIL r0_mask: got %0h expected 0", mask); end
        step();
    endtask

    task automatic test_fill_backpressure();
        drain_en = 1'b0;
        for (int g = 0; g < 4; g++) begin
            valid = 2'b11;
            regs[0] = 5'(10 + 2*g);       regs[1] = 5'(11 + 2*g);
            data[0] = 32'(256 + 10 + 2*g); data[1] = 32'(256 + 11 + 2*g);
            #1;
            n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_g%0d: got %0b expected 1", g, ready); end
            step();
            if (g == 2) begin
                n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL fill_count6: got %0d expected 6", count); end
            end
        end
        valid = 2'b11; regs[0] = 5'd18; regs[1] = 5'd19; data[0] = 32'd274; data[1] = 32'd275;
        #1;
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count: got %0d expected 8", count); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b expected 0", ready); end
        n_cmp++; if (mask !== 32'h0003FC00) begin n_bad++; $display("FAIL full_mask: got %0h expected 3fc00", mask); end
        step();
        step();
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL held_count: got %0d expected 8", count); end
        drain_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (ports[0].write_enable !== 1'b1 || ports[0].register !== 5'(10 + 2*c) || ports[0].data !== 32'(266 + 2*c)) begin
                n_bad++; $display("FAIL order_p0_c%0d: got we=%0b r=%0d d=%0d expected we=1 r=%0d d=%0d",
                                  c, ports[0].write_enable, ports[0].register, ports[0].data, 10 + 2*c, 266 + 2*c); end
            n_cmp++; if (ports[1].write_enable !== 1'b1 || ports[1].register !== 5'(11 + 2*c) || ports[1].data !== 32'(267 + 2*c)) begin
                n_bad++; $display("FAIL order_p1_c%0d: got we=%0b r=%0d d=%0d expected we=1 r=%0d d=%0d",
                                  c, ports[1].write_enable, ports[1].register, ports[1].data, 11 + 2*c, 267 + 2*c); end
            if (c == 0) begin
                n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL drain0_ready: got %0b expected 0", ready); end
            end
            if (c == 1) begin
                n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL drain1_ready: got %0b expected 1", ready); end
            end
            step();
            if (c == 1) begin
                valid = '0;
                n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL enq_drain_count: got %0d expected 6", count); end
            end
        end
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL fill_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_collision();
        drain_en = 1'b0; valid = 2'b11; regs[0] = 5'd3; regs[1] = 5'd3; data[0] = 32'hA; data[1] = 32'hB;
        step();
        valid = '0;
        #1;
        n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL coll_count: got %0d expected 2", count); end
        n_cmp++; if (mask !== 32'h8) begin n_bad++; $display("FAIL coll_mask: got %0h expected 8", mask); end
        drain_en = 1'b1;
        #1;
        n_cmp++; if (ports[0].write_enable !== 1'b0) begin n_bad++; $display("FAIL coll_p0_we: got %0b expected 0", ports[0].write_enable); end
        n_cmp++; if (ports[1].write_enable !== 1'b1 || ports[1].register !== 5'd3 || ports[1].data !== 32'hB) begin
            n_bad++; $display("FAIL coll_p1: got we=%0b r=%0d d=%0h expected we=1 r=3 d=b",
                              ports[1].write_enable, ports[1].register, ports[1].data); end
        step();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL coll_retired: got %0d expected 0", count); end
    endtask

    task automatic test_concurrent();
        drain_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            valid = 2'b11;
            regs[0] = 5'(20 + 2*g); regs[1] = 5'(21 + 2*g);
            data[0] = 32'(20 + 2*g); data[1] = 32'(21 + 2*g);
            step();
        end
        valid = 2'b01; regs[0] = 5'd26; data[0] = 32'd26;
        step();
        valid = 2'b11; regs[0] = 5'd27; regs[1] = 5'd28; data[0] = 32'd27; data[1] = 32'd28; drain_en = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL conc_count7: got %0d expected 7", count); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL conc_ready7: got %0b expected 0", ready); end
        step();
        valid = '0; drain_en = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL conc_count5: got %0d expected 5", count); end
        valid = 2'b01; regs[0] = 5'd27; data[0] = 32'd27;
        step();
        valid = 2'b11; regs[0] = 5'd28; regs[1] = 5'd29; data[0] = 32'd28; data[1] = 32'd29; drain_en = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL conc_ready6: got %0b expected 1", ready); end
        step();
        valid = '0;
        #1;
        n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL conc_count6: got %0d expected 6", count); end
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (ports[0].register !== 5'(24 + 2*c) || ports[1].register !== 5'(25 + 2*c) ||
                         ports[0].data !== 32'(24 + 2*c) || ports[1].data !== 32'(25 + 2*c)) begin
                n_bad++; $display("FAIL conc_order_c%0d: got r=%0d,%0d d=%0d,%0d expected r=%0d,%0d",
                                  c, ports[0].register, ports[1].register, ports[0].data, ports[1].data, 24 + 2*c, 25 + 2*c); end
            step();
        end
        #1;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL conc_final: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_compaction();
        test_fill_backpressure();
        test_collision();
        test_concurrent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name:
writeback_queue

Overview:
- Writeback buffer directly upstream of register_file.
- Accepts up to SUPER_SCALAR_WIDTH completed results per cycle from the execute stage into an in-order circular queue.
- Drains the oldest entries onto register_file's write ports, as RegisterFileWriteRequest, up to SUPER_SCALAR_WIDTH per cycle.
- Exports a pending-register mask so issue logic can hold off reads of registers whose writes are still queued.

Parameters:
- SUPER_SCALAR_WIDTH, 2, number of result lanes in and write ports out.
- DEPTH, 8, queue entries; power of two, at least 2*SUPER_SCALAR_WIDTH.
- REG_ADDR_WIDTH, 5, register index width; equals $clog2(REGISTER_FILE_SIZE).
- DATA_WIDTH, 32, width of Word.

Ports:
- clk_in  input  1  clock; single clock domain.
- rst_in  input  1  synchronous, active-high reset.
- result_valid_in  input  [SUPER_SCALAR_WIDTH] x 1  lane carries a completed result.
- result_register_in  input  [SUPER_SCALAR_WIDTH] x REG_ADDR_WIDTH  destination register per lane.
- result_data_in  input  [SUPER_SCALAR_WIDTH] x DATA_WIDTH  result Word per lane.
- result_ready_out  output  1  queue accepts the full lane group this cycle.
- drain_enable_in  input  1  permits writes to register_file this cycle; low stalls the drain.
- write_ports_reg_request_out  output  [SUPER_SCALAR_WIDTH] RegisterFileWriteRequest  fields write_enable, register, data; port i feeds register_file write port i.
- pending_register_mask_out  output  2**REG_ADDR_WIDTH  bit r is set while any queued entry targets register r.
- count_out  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- State:
  - storage array of DEPTH entries {register, data};
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count register.
- Reset, applied at the first posedge with rst_in=1:
  - head=tail=count=0; storage contents don't-care;
  - while rst_in=1: result_ready_out=0, all write_enable=0, pending_register_mask_out=0, count_out=0.
  - Reset mid-operation discards all queued entries; none are written.
- Handshake:
  - result_ready_out = !rst_in && (DEPTH - count) >= SUPER_SCALAR_WIDTH.
  - The ready check uses count before this cycle's drain; it is conservative and never depends on drain.
  - A lane is accepted at a posedge when result_valid_in[i] && result_ready_out.
  - Valid lanes presented while ready=0 are not captured; upstream must hold them.
- Enqueue order:
  - Accepted lanes are compacted in lane order, lane 0 oldest, into tail, tail+1, ...
  - Invalid lanes leave no gaps.
- Register 0:
  - A lane with result_register_in=0 is accepted (counts toward the handshake) but is not enqueued.
  - It never raises a write or a mask bit.
- Drain (combinational from head):
  - n = min(count, SUPER_SCALAR_WIDTH).
  - Port j (j<n) presents entry head+j with write_enable = drain_enable_in, subject to collision suppression.
  - Ports j>=n have write_enable=0, register=0, data=0.
- Drain advance:
  - If drain_enable_in=1, head advances by n and count decreases by n at the posedge.
  - If drain_enable_in=0, head and count hold.
- Same-register collision:
  - If ports j<k in one drain group target the same register, port j's write_enable is forced to 0, so only the youngest write reaches register_file.
  - The suppressed entry is still retired.
- Latency:
  - A result accepted at posedge N is on the write port during cycle N+1 at the earliest.
  - It is written into register_file at posedge N+1.
- Simultaneous enqueue and drain in one cycle: count_next = count + accepted_nonzero - drained.
- Occupancy bounds: count never exceeds DEPTH and never underflows; the wrap from DEPTH-1 to 0 is seamless.
- pending_register_mask_out:
  - OR over occupied entries of one-hot(register).
  - Combinational from current state; it excludes entries arriving this cycle.
  - Bit 0 is always 0.
- Entries are written to register_file strictly in acceptance order; no reordering across drain groups.

Test Plan:
- Reset then idle:
  - ready=1, count_out=0, all write_enable=0, mask=0.
  - Assert rst_in for one cycle with 3 entries queued -> count_out=0 the next cycle and no writes ever issue.
- Single lane:
  - Lane 0 {r5, 0xDEADBEEF} valid, drain_enable_in=1 -> the next cycle port 0 shows write_enable=1, register=5, data=0xDEADBEEF, and mask bit 5 is set.
  - The cycle after: count_out=0 and mask=0.
- Compaction:
  - Lane 0 invalid, lane 1 {r7, 0x11} -> stored at tail and appears on port 0, not port 1.
  - Lane 1 {r0, 0x22} -> accepted, with no write and count unchanged.
- Fill and backpressure:
  - drain_enable_in=0 and 2 results/cycle for 3 cycles -> count_out=6.
  - 4th group accepted -> count=8, ready=0.
  - 5th group held until drain_enable_in=1.
  - Drain order equals acceptance order across the wrap of head and tail.
- Collision:
  - Queue {r3, 0xA} then {r3, 0xB} in one group, drained together -> port 0 write_enable=0, port 1 writes r3=0xB, count drops by 2.
- Concurrent:
  - count=7, enqueue 2 while draining 2 -> ready=0 that cycle (7 > DEPTH-2), no accept, count becomes 5.
  - count=6 -> accept and drain 2 in the same cycle, count stays 6.
